// File: rtl/adsr_voice_scheduler.sv
// Per-voice ADSR sequencer: owns the voice table, applies note events, and scans all voices per sample tick.
// Optional build macro ADSR_SKIP_BLANK_EN: idle BLANK voices take one FETCH cycle and produce no write-back or strobe.
module adsr_voice_scheduler #(
  parameter int NB_VOICE = 16,
  parameter int VIDX_W   = 4
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sample_tick,
  input  logic              i_evt_valid,
  output logic              o_evt_ready,
  input  logic [VIDX_W-1:0] i_evt_voice,
  input  logic              i_evt_on,
  input  logic [3:0]        i_evt_channel,
  output logic [2:0]        o_adsr_state,
  output logic [17:0]       o_adsr_volume,
  output logic              o_adsr_note_pressed,
  output logic              o_adsr_note_released,
  output logic [3:0]        o_adsr_channel,
  input  logic [2:0]        i_adsr_state,
  input  logic [17:0]       i_adsr_volume,
  input  logic              i_adsr_note_pressed,
  input  logic              i_adsr_note_released,
  output logic              o_voice_valid,
  output logic [VIDX_W-1:0] o_voice_idx,
  output logic [17:0]       o_voice_volume,
  output logic [2:0]        o_voice_state,
  output logic              o_busy,
  output logic              o_overrun,
  output logic [1:0]        o_dbg_fsm_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_WRITE = 2'd2
  } fsm_t;

  typedef struct packed {
    logic [2:0]  state;
    logic [17:0] volume;
    logic        pressed;
    logic        released;
    logic [3:0]  channel;
  } voice_t;

  fsm_t              r_state;
  fsm_t              w_state_next;
  logic [VIDX_W-1:0] r_idx;
  logic [VIDX_W-1:0] w_idx_next;
  voice_t            r_tbl [NB_VOICE];
  voice_t            r_adsr;
  logic              r_pend_pressed;
  logic              r_pend_released;
  logic              r_voice_valid;
  logic [VIDX_W-1:0] r_voice_idx;
  logic [17:0]       r_voice_volume;
  logic [2:0]        r_voice_state;
  logic              r_overrun;
  logic              w_last;
  logic              w_skip;
  logic              w_evt_fire;
  logic              w_evt_here;

  // Event handshake: an event transfers on a rising clock edge where i_evt_valid && o_evt_ready.
  // Ready drops only in WRITE, so the table never sees an event write and a write-back together.
  assign o_evt_ready = (r_state != S_WRITE);
  assign w_evt_fire  = i_evt_valid && o_evt_ready;
  assign w_evt_here  = w_evt_fire && (i_evt_voice == r_idx) && (r_state == S_FETCH);
  assign w_last      = (r_idx == VIDX_W'(NB_VOICE - 1));

`ifdef ADSR_SKIP_BLANK_EN
  localparam logic [2:0] ST_BLANK = 3'd0;
  assign w_skip = (r_tbl[r_idx].state == ST_BLANK) && !r_tbl[r_idx].pressed;
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (i_sample_tick) begin
          w_state_next = S_FETCH;
          w_idx_next   = '0;
        end
      end
      S_FETCH: begin
        if (!w_skip) begin
          w_state_next = S_WRITE;
        end else if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_idx_next = r_idx + 1'b1;
        end
      end
      S_WRITE: begin
        if (w_last) begin
          w_state_next = S_IDLE;
        end else begin
          w_state_next = S_FETCH;
          w_idx_next   = r_idx + 1'b1;
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int v = 0; v < NB_VOICE; v++) begin
        r_tbl[v] <= '0;
      end
    end else begin
      if (r_state == S_WRITE) begin
        r_tbl[r_idx].state    <= i_adsr_state;
        r_tbl[r_idx].volume   <= i_adsr_volume;
        r_tbl[r_idx].pressed  <= i_adsr_note_pressed | r_pend_pressed;
        r_tbl[r_idx].released <= i_adsr_note_released | r_pend_released;
      end
      if (w_evt_fire) begin
        if (i_evt_on) begin
          r_tbl[i_evt_voice].pressed  <= 1'b1;
          r_tbl[i_evt_voice].released <= 1'b0;
          r_tbl[i_evt_voice].channel  <= i_evt_channel;
        end else begin
          r_tbl[i_evt_voice].pressed  <= 1'b0;
          r_tbl[i_evt_voice].released <= 1'b1;
        end
      end
    end
  end

  // An event that lands on the voice being fetched misses the snapshot, so it is re-merged at write-back.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pend_pressed  <= 1'b0;
      r_pend_released <= 1'b0;
      r_adsr          <= '0;
    end else if (r_state == S_FETCH) begin
      r_pend_pressed  <= w_evt_here && i_evt_on;
      r_pend_released <= w_evt_here && !i_evt_on;
      r_adsr          <= r_tbl[r_idx];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_voice_valid  <= 1'b0;
      r_voice_idx    <= '0;
      r_voice_volume <= '0;
      r_voice_state  <= '0;
      r_overrun      <= 1'b0;
    end else begin
      r_voice_valid <= (r_state == S_WRITE);
      r_overrun     <= i_sample_tick && (r_state != S_IDLE);
      if (r_state == S_WRITE) begin
        r_voice_idx    <= r_idx;
        r_voice_volume <= i_adsr_volume;
        r_voice_state  <= i_adsr_state;
      end
    end
  end

  assign o_adsr_state         = r_adsr.state;
  assign o_adsr_volume        = r_adsr.volume;
  assign o_adsr_note_pressed  = r_adsr.pressed;
  assign o_adsr_note_released = r_adsr.released;
  assign o_adsr_channel       = r_adsr.channel;
  assign o_voice_valid        = r_voice_valid;
  assign o_voice_idx          = r_voice_idx;
  assign o_voice_volume       = r_voice_volume;
  assign o_voice_state        = r_voice_state;
  assign o_busy               = (r_state != S_IDLE);
  assign o_overrun            = r_overrun;
  assign o_dbg_fsm_state      = r_state;

endmodule

// File: tb/tb_adsr_voice_scheduler.sv
// Directed bench for adsr_voice_scheduler: bench-side ADSR calculator, voice-table model and
// cycle-stamped scoreboards for the voice strobes and the presented calculator inputs.
module tb_adsr_voice_scheduler;

  localparam int NB_VOICE = 16;
  localparam int VIDX_W   = 4;

  typedef struct packed {
    logic [2:0]  st;
    logic [17:0] vol;
    logic        p;
    logic        r;
    logic [3:0]  ch;
  } ent_t;

  logic              i_clk = 1'b0;
  logic              i_rst = 1'b1;
  logic              i_sample_tick = 1'b0;
  logic              i_evt_valid = 1'b0;
  logic              o_evt_ready;
  logic [VIDX_W-1:0] i_evt_voice = '0;
  logic              i_evt_on = 1'b0;
  logic [3:0]        i_evt_channel = '0;
  logic [2:0]        o_adsr_state;
  logic [17:0]       o_adsr_volume;
  logic              o_adsr_note_pressed;
  logic              o_adsr_note_released;
  logic [3:0]        o_adsr_channel;
  logic [2:0]        i_adsr_state;
  logic [17:0]       i_adsr_volume;
  logic              i_adsr_note_pressed;
  logic              i_adsr_note_released;
  logic              o_voice_valid;
  logic [VIDX_W-1:0] o_voice_idx;
  logic [17:0]       o_voice_volume;
  logic [2:0]        o_voice_state;
  logic              o_busy;
  logic              o_overrun;
  logic [1:0]        o_dbg_fsm_state;

  adsr_voice_scheduler #(.NB_VOICE(NB_VOICE), .VIDX_W(VIDX_W)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_sample_tick(i_sample_tick),
    .i_evt_valid(i_evt_valid), .o_evt_ready(o_evt_ready), .i_evt_voice(i_evt_voice),
    .i_evt_on(i_evt_on), .i_evt_channel(i_evt_channel),
    .o_adsr_state(o_adsr_state), .o_adsr_volume(o_adsr_volume),
    .o_adsr_note_pressed(o_adsr_note_pressed), .o_adsr_note_released(o_adsr_note_released),
    .o_adsr_channel(o_adsr_channel),
    .i_adsr_state(i_adsr_state), .i_adsr_volume(i_adsr_volume),
    .i_adsr_note_pressed(i_adsr_note_pressed), .i_adsr_note_released(i_adsr_note_released),
    .o_voice_valid(o_voice_valid), .o_voice_idx(o_voice_idx), .o_voice_volume(o_voice_volume),
    .o_voice_state(o_voice_state), .o_busy(o_busy), .o_overrun(o_overrun),
    .o_dbg_fsm_state(o_dbg_fsm_state)
  );

  // ---------------- clock / reset ----------------
  always #5 i_clk = ~i_clk;

  int cyc = 0;
  always @(posedge i_clk) cyc <= cyc + 1;

  // ---------------- bench ADSR calculator ----------------
  function automatic ent_t calc(input ent_t e);
    ent_t n;
    n   = e;
    n.p = 1'b0;
    n.r = 1'b0;
    if (e.p) begin
      n.st  = 3'd1;
      n.vol = e.vol + 18'd5;
    end else if (e.r) begin
      n.st  = 3'd4;
      n.vol = e.vol >> 1;
    end
    return n;
  endfunction

  ent_t cur_in, cur_out;
  always_comb begin
    cur_in  = {o_adsr_state, o_adsr_volume, o_adsr_note_pressed, o_adsr_note_released, o_adsr_channel};
    cur_out = calc(cur_in);
  end
  assign i_adsr_state         = cur_out.st;
  assign i_adsr_volume        = cur_out.vol;
  assign i_adsr_note_pressed  = cur_out.p;
  assign i_adsr_note_released = cur_out.r;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  int ovr_cnt = 0;
  logic [56:0] exp_q[$];   // {cycle, idx, state, volume} of each voice strobe
  logic [58:0] adsr_q[$];  // {cycle, entry} presented to the calculator in WRITE

  ent_t mdl [NB_VOICE];
  int   fetch_cyc [NB_VOICE];
  int   write_cyc [NB_VOICE];
  int   busy_end = 0;
  int   last_t = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge i_clk) begin
    if (!i_rst) begin
      if (o_voice_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_strobe", {32'(cyc), o_voice_idx, o_voice_state, o_voice_volume}, 64'd0);
        end else begin
          chk("strobe", {32'(cyc), o_voice_idx, o_voice_state, o_voice_volume}, exp_q.pop_front());
        end
      end
      if (adsr_q.size() != 0 && cyc >= int'(adsr_q[0][58:27])) begin
        chk("adsr_in", {32'(cyc), o_adsr_state, o_adsr_volume, o_adsr_note_pressed,
                        o_adsr_note_released, o_adsr_channel}, adsr_q.pop_front());
      end
      if (o_overrun) ovr_cnt++;
    end
  end

  // ---------------- model / driver tasks ----------------
  task automatic model_pass(input int t);
    int   c;
    bit   skip;
    ent_t n;
    c = t + 1;
    for (int v = 0; v < NB_VOICE; v++) begin
      fetch_cyc[v] = c;
      skip = 1'b0;
`ifdef ADSR_SKIP_BLANK_EN
      skip = (mdl[v].st == 3'd0) && !mdl[v].p;
`endif
      if (skip) begin
        write_cyc[v] = -1;
        c = c + 1;
      end else begin
        write_cyc[v] = c + 1;
        adsr_q.push_back({32'(c + 1), mdl[v]});
        n = calc(mdl[v]);
        exp_q.push_back({32'(c + 2), VIDX_W'(v), n.st, n.vol});
        mdl[v] = {n.st, n.vol, n.p, n.r, mdl[v].ch};
        c = c + 2;
      end
    end
    busy_end = c - 1;
  endtask

  task automatic mdl_evt(input int v, input bit on, input logic [3:0] ch);
    if (on) begin
      mdl[v].p  = 1'b1;
      mdl[v].r  = 1'b0;
      mdl[v].ch = ch;
    end else begin
      mdl[v].p = 1'b0;
      mdl[v].r = 1'b1;
    end
  endtask

  task automatic send_evt(input int v, input bit on, input logic [3:0] ch);
    int n;
    n = 0;
    i_evt_valid   = 1'b1;
    i_evt_voice   = VIDX_W'(v);
    i_evt_on      = on;
    i_evt_channel = ch;
    while (!o_evt_ready && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    chk("evt_ready_wait", o_evt_ready, 1);
    @(negedge i_clk);
    i_evt_valid = 1'b0;
    mdl_evt(v, on, ch);
  endtask

  task automatic do_pass();
    i_sample_tick = 1'b1;
    last_t = cyc;
    model_pass(cyc);
    @(negedge i_clk);
    i_sample_tick = 1'b0;
  endtask

  task automatic finish_pass();
    while (cyc < busy_end) @(negedge i_clk);
    chk("busy_last", o_busy, 1);
    @(negedge i_clk);
    chk("busy_fall", o_busy, 0);
  endtask

  task automatic reset_model();
    for (int v = 0; v < NB_VOICE; v++) mdl[v] = '0;
    exp_q.delete();
    adsr_q.delete();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic [3:0] ch5;
    int         tgt;
    reset_model();
    repeat (3) @(negedge i_clk);
    i_rst = 1'b0;
    chk("rst_ready", o_evt_ready, 1);
    chk("rst_busy", o_busy, 0);
    chk("rst_valid", o_voice_valid, 0);
    chk("rst_overrun", o_overrun, 0);
    chk("rst_adsr", {o_adsr_state, o_adsr_volume, o_adsr_note_pressed, o_adsr_note_released, o_adsr_channel}, 0);
    chk("rst_voice", {o_voice_idx, o_voice_state, o_voice_volume}, 0);
    chk("rst_fsm", o_dbg_fsm_state, 0);

    // Pass A: idle table, all strobes zero
    do_pass();
    finish_pass();

    // Pass B: note-on voice 3 ch 2, plus an overrun tick at T+10
    send_evt(3, 1'b1, 4'd2);
    do_pass();
    while (cyc < last_t + 10) @(negedge i_clk);
    i_sample_tick = 1'b1;
    @(negedge i_clk);
    i_sample_tick = 1'b0;
    finish_pass();
    chk("overrun_count", ovr_cnt, 1);

    // Pass C: note-on voice 5 in its FETCH cycle; note-off voice 7 held across its WRITE
    ch5 = 4'($urandom_range(0, 15));
    do_pass();
    while (cyc < fetch_cyc[5]) @(negedge i_clk);
    send_evt(5, 1'b1, ch5);
    tgt = (write_cyc[7] >= 0) ? write_cyc[7] : fetch_cyc[7];
    while (cyc < tgt) @(negedge i_clk);
    if (write_cyc[7] >= 0) begin
      i_evt_valid = 1'b1;
      i_evt_voice = VIDX_W'(7);
      i_evt_on    = 1'b0;
      chk("ready_in_write", o_evt_ready, 0);
      @(negedge i_clk);
    end
    send_evt(7, 1'b0, 4'($urandom_range(0, 15)));
    finish_pass();

    // Pass D sees the deferred events; pass E starts on the first legal cycle after it
    do_pass();
    finish_pass();
    do_pass();
    finish_pass();
    chk("no_extra_overrun", ovr_cnt, 1);

    // Reset in mid-pass, then only voice 0 active
    do_pass();
    while (cyc < last_t + 6) @(negedge i_clk);
    @(posedge i_clk);
    #1;
    i_rst = 1'b1;
    reset_model();
    @(negedge i_clk);
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_busy", o_busy, 0);
    chk("midrst_valid", o_voice_valid, 0);
    chk("midrst_adsr", {o_adsr_state, o_adsr_volume, o_adsr_note_pressed, o_adsr_channel}, 0);
    send_evt(0, 1'b1, 4'd9);
    do_pass();
    finish_pass();

    @(negedge i_clk);
    @(negedge i_clk);
    chk("strobes_drained", exp_q.size(), 0);
    chk("adsr_drained", adsr_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
